seq_judge: RTL and testbench

Round-result judge that sits directly downstream of the player-input synchroniser in the memory-sequence game. It consumes the packed 4-bit-per-key player sequence and the input-complete flag, compares the sequence nibble by nibble against the target sequence from the pattern generator, and produces a one-cycle result pulse. It also maintains the BCD score, the lives counter and the game-over flag that the top-level FSM and the display path read.

---
 rtl/game_pkg.sv | 38 +++
 rtl/seq_judge_if.sv | 36 +++
 rtl/bcd_score_counter.sv | 29 ++
 rtl/seq_judge.sv | 184 ++++++++++++++++++
 tb/tb_seq_judge.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-sequence game.
// Keys are packed one nibble per key, key 0 in the low nibble.
package game_pkg;

    localparam int MAX_K   = 8;
    localparam int KEY_W   = 4;
    localparam int SEQ_W   = 32;
    localparam int LIVES_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COMPARE,
        S_HOLD_PASS,
        S_HOLD_FAIL,
        S_OVER
    } state_t;

    function automatic logic [KEY_W-1:0] key_at(
        input logic [SEQ_W-1:0] seq,
        input logic [2:0]       i
    );
        logic [SEQ_W-1:0] sh;
        sh = seq >> (KEY_W * int'(i));
        return sh[KEY_W-1:0];
    endfunction

    // Zero keys still needs one key; more than MAX_K cannot be packed.
    function automatic logic [3:0] eff_k(input logic [3:0] k);
        if (k == 4'd0)
            return 4'd1;
        else if (k > 4'(MAX_K))
            return 4'(MAX_K);
        else
            return k;
    endfunction

endpackage

// File: rtl/seq_judge_if.sv
// Round-input / verdict bundle between the input stage and seq_judge.
// master drives the round inputs, slave is the judge.
interface seq_judge_if;
    import game_pkg::*;

    logic               start;
    logic               judge_en;
    logic               input_done;
    logic [3:0]         input_cnt;
    logic [SEQ_W-1:0]   user_seq;
    logic [SEQ_W-1:0]   target_seq;
    logic [3:0]         difficulty_k;

    logic               busy;
    logic               result_valid;
    logic               result_pass;
    logic [3:0]         mismatch_idx;
    logic [7:0]         score;
    logic [LIVES_W-1:0] lives;
    logic               game_over;

    modport master (
        output start, judge_en, input_done, input_cnt,
        output user_seq, target_seq, difficulty_k,
        input  busy, result_valid, result_pass, mismatch_idx,
        input  score, lives, game_over
    );

    modport slave (
        input  start, judge_en, input_done, input_cnt,
        input  user_seq, target_seq, difficulty_k,
        output busy, result_valid, result_pass, mismatch_idx,
        output score, lives, game_over
    );

endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score, tens in [7:4], saturating at 99.
module bcd_score_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] score
);

    logic [3:0] ones;
    logic [3:0] tens;

    assign ones = score[3:0];
    assign tens = score[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            score <= 8'h00;
        else if (clr)
            score <= 8'h00;
        else if (inc && score != 8'h99) begin
            if (ones == 4'd9)
                score <= {tens + 4'd1, 4'd0};
            else
                score <= {tens, ones + 4'd1};
        end
    end

endmodule

// File: rtl/seq_judge.sv
// Round-result judge: nibble-serial compare of player vs target keys,
// one-cycle verdict pulse, BCD score, lives and game-over tracking.
module seq_judge
    import game_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int LIVES_INIT  = 3
) (
    input  logic      clk,
    input  logic      rst,
    seq_judge_if.slave bus
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

    state_t state;
    state_t state_d;

    logic               done_q;
    logic               rise;
    logic [SEQ_W-1:0]   u_q;
    logic [SEQ_W-1:0]   t_q;
    logic [3:0]         cnt_q;
    logic [3:0]         k_q;
    logic               to_q;
    logic [3:0]         idx_q;
    logic [3:0]         idx_d;
    logic [HW-1:0]      hold_q;
    logic [HW-1:0]      hold_d;

    logic               verdict;
    logic               pass_v;
    logic               latch_en;
    logic [3:0]         fail_idx;

    logic               rv_q;
    logic               pass_q;
    logic [3:0]         mis_q;
    logic               busy_q;
    logic               over_q;
    logic [LIVES_W-1:0] lives_q;
    logic [7:0]         score;

    assign rise = bus.input_done & ~done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d  = state;
        verdict  = 1'b0;
        pass_v   = 1'b0;
        latch_en = 1'b0;
        fail_idx = 4'd0;
        idx_d    = idx_q;
        hold_d   = hold_q;
        unique case (state)
            S_IDLE: begin
                if (bus.judge_en)
                    state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!bus.judge_en)
                    state_d = S_IDLE;
                else if (rise) begin
                    latch_en = 1'b1;
                    idx_d    = 4'd0;
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // A short entry is judged before any key is looked at.
                if (to_q) begin
                    verdict  = 1'b1;
                    fail_idx = cnt_q;
                end else if (key_at(u_q, idx_q[2:0])
                             != key_at(t_q, idx_q[2:0])) begin
                    verdict  = 1'b1;
                    fail_idx = idx_q;
                end else if (idx_q == k_q - 4'd1) begin
                    verdict = 1'b1;
                    pass_v  = 1'b1;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
                if (verdict) begin
                    hold_d = '0;
                    if (pass_v)
                        state_d = S_HOLD_PASS;
                    else if (lives_q == LIVES_W'(1))
                        state_d = S_OVER;
                    else
                        state_d = S_HOLD_FAIL;
                end
            end
            S_HOLD_PASS, S_HOLD_FAIL: begin
                if (hold_q == HOLD_LAST)
                    state_d = bus.judge_en ? S_ARMED : S_IDLE;
                else
                    hold_d = hold_q + 1'b1;
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.start) begin
            state_d  = S_IDLE;
            verdict  = 1'b0;
            pass_v   = 1'b0;
            latch_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            u_q     <= '0;
            t_q     <= '0;
            cnt_q   <= 4'd0;
            k_q     <= 4'd1;
            to_q    <= 1'b0;
            idx_q   <= 4'd0;
            hold_q  <= '0;
            rv_q    <= 1'b0;
            pass_q  <= 1'b0;
            mis_q   <= 4'd0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            lives_q <= LIVES_RST;
        end else begin
            done_q <= bus.input_done & ~bus.start;
            idx_q  <= idx_d;
            hold_q <= hold_d;
            rv_q   <= verdict;
            // Lags the state by one cycle so it rises one cycle after latch.
            busy_q <= ~bus.start & (state inside
                      {S_COMPARE, S_HOLD_PASS, S_HOLD_FAIL});
            over_q <= (state_d == S_OVER);
            if (latch_en) begin
                u_q   <= bus.user_seq;
                t_q   <= bus.target_seq;
                cnt_q <= bus.input_cnt;
                k_q   <= eff_k(bus.difficulty_k);
                to_q  <= bus.input_cnt < eff_k(bus.difficulty_k);
            end
            if (bus.start) begin
                pass_q  <= 1'b0;
                mis_q   <= 4'd0;
                lives_q <= LIVES_RST;
            end else if (verdict) begin
                pass_q <= pass_v;
                mis_q  <= pass_v ? 4'd0 : fail_idx;
                if (!pass_v)
                    lives_q <= lives_q - 1'b1;
            end
        end
    end

    bcd_score_counter u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.start),
        .inc   (verdict & pass_v),
        .score (score)
    );

    assign bus.busy         = busy_q;
    assign bus.result_valid = rv_q;
    assign bus.result_pass  = pass_q;
    assign bus.mismatch_idx = mis_q;
    assign bus.score        = score;
    assign bus.lives        = lives_q;
    assign bus.game_over    = over_q;

endmodule

// File: tb/tb_seq_judge.sv
// Scoreboard bench for seq_judge: directed rounds push expected verdicts,
// a negedge monitor pops and compares on every result_valid.
module tb_seq_judge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_judge_if bus ();

    seq_judge #(
        .HOLD_CYCLES (4),
        .LIVES_INIT  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        bit         pass;
        logic [3:0] idx;
        logic [7:0] score;
        logic [1:0] lives;
        bit         over;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors  = 0;
    int   checks  = 0;
    int   seen    = 0;
    int   m_score = 0;
    int   m_lives = 3;

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.result_valid) begin
            seen++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_verdict cyc=%0d pass=%0b",
                         cyc, bus.result_pass);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || bus.result_pass != e.pass ||
                    bus.mismatch_idx !== e.idx ||
                    bus.score !== e.score || bus.lives !== e.lives ||
                    bus.game_over != e.over) begin
                    errors++;
                    $display({"FAIL verdict got cyc=%0d pass=%0b idx=%0d",
                              " score=%h lives=%0d over=%0b, want cyc=%0d",
                              " pass=%0b idx=%0d score=%h lives=%0d over=%0b"},
                             cyc, bus.result_pass, bus.mismatch_idx,
                             bus.score, bus.lives, bus.game_over,
                             e.cyc, e.pass, e.idx, e.score, e.lives, e.over);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        tick();
        tick();
    endtask

    task automatic drive(input logic [3:0] k, input logic [3:0] cnt,
                         input logic [31:0] u, input logic [31:0] t);
        bus.difficulty_k = k;
        bus.input_cnt    = cnt;
        bus.user_seq     = u;
        bus.target_seq   = t;
        bus.input_done   = 1'b1;
    endtask

    task automatic round(input string nm, input logic [3:0] k,
                         input logic [3:0] cnt, input logic [31:0] u,
                         input logic [31:0] t, input bit p,
                         input logic [3:0] ix, input int lat);
        exp_t x;
        int   n;
        int   s0;
        int   b;
        settle();
        drive(k, cnt, u, t);
        if (p)
            m_score = (m_score < 99) ? m_score + 1 : 99;
        else
            m_lives--;
        x.cyc   = cyc + 1 + lat;
        x.pass  = p;
        x.idx   = p ? 4'd0 : ix;
        x.score = bcd(m_score);
        x.lives = 2'(m_lives);
        x.over  = (m_lives == 0);
        q.push_back(x);
        s0 = seen;
        tick();
        chk({nm, "_busy_c0"}, 32'(bus.busy), 0);
        tick();
        chk({nm, "_busy_c1"}, 32'(bus.busy), 1);
        n = 0;
        while (seen == s0 && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_verdicts"}, seen - s0, 1);
        b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy)
                b++;
            else
                break;
        end
        chk({nm, "_hold"}, b, x.over ? 0 : 4);
        bus.input_done = 1'b0;
    endtask

    initial begin
        int s0;
        bus.start        = 1'b0;
        bus.judge_en     = 1'b0;
        bus.input_done   = 1'b0;
        bus.input_cnt    = 4'd0;
        bus.user_seq     = 32'h0;
        bus.target_seq   = 32'h0;
        bus.difficulty_k = 4'd0;
        repeat (3) tick();
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.result_valid), 0);
        chk("rst_pass",  32'(bus.result_pass), 0);
        chk("rst_idx",   32'(bus.mismatch_idx), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_lives", 32'(bus.lives), 3);
        chk("rst_over",  32'(bus.game_over), 0);
        rst = 1'b0;
        bus.judge_en = 1'b1;

        round("perfect", 4'd4, 4'd4, 32'h4321, 32'h4321, 1, 0, 4);
        round("mismatch", 4'd5, 4'd5, 32'h54321, 32'h55321, 0, 3, 4);
        round("timeout", 4'd6, 4'd2, 32'h21, 32'h654321, 0, 2, 1);
        round("lastlife", 4'd5, 4'd5, 32'h54321, 32'h54921, 0, 2, 3);
        chk("over_flag",  32'(bus.game_over), 1);
        chk("over_lives", 32'(bus.lives), 0);

        s0 = seen;
        tick();
        bus.input_done = 1'b1;
        repeat (10) tick();
        chk("over_ignores_done", seen - s0, 0);
        chk("over_stays", 32'(bus.game_over), 1);
        bus.input_done = 1'b0;

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_score = 0;
        m_lives = 3;
        chk("start_lives", 32'(bus.lives), 3);
        chk("start_score", 32'(bus.score), 0);
        chk("start_over",  32'(bus.game_over), 0);

        round("k0_as_1", 4'd0, 4'd1, 32'h1, 32'h1, 1, 0, 1);
        round("k9_as_8", 4'd9, 4'd8, 32'h87654321, 32'h87654321, 1, 0, 8);
        while (m_score < 99)
            round("score_run", 4'd1, 4'd1, 32'h5, 32'h5, 1, 0, 1);
        round("score_sat", 4'd1, 4'd1, 32'h7, 32'h7, 1, 0, 1);

        settle();
        drive(4'd4, 4'd4, 32'h4321, 32'h4321);
        s0 = seen;
        repeat (4) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_score = 0;
        m_lives = 3;
        chk("start_final_valid", 32'(bus.result_valid), 0);
        chk("start_final_score", 32'(bus.score), 0);
        chk("start_final_lives", 32'(bus.lives), 3);
        repeat (8) tick();
        chk("start_final_none", seen - s0, 0);
        bus.input_done = 1'b0;
        tick();

        round("pre_rst_pass", 4'd1, 4'd1, 32'h3, 32'h3, 1, 0, 1);
        round("pre_rst_fail", 4'd3, 4'd2, 32'h12, 32'h312, 0, 2, 1);
        settle();
        drive(4'd8, 4'd8, 32'h87654321, 32'h87654321);
        s0 = seen;
        repeat (3) tick();
        chk("mid_cmp_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("arst_busy",  32'(bus.busy), 0);
        chk("arst_score", 32'(bus.score), 0);
        chk("arst_lives", 32'(bus.lives), 3);
        chk("arst_idx",   32'(bus.mismatch_idx), 0);
        chk("arst_pass",  32'(bus.result_pass), 0);
        repeat (3) tick();
        bus.input_done = 1'b0;
        rst = 1'b0;
        repeat (12) tick();
        chk("arst_no_verdict", seen - s0, 0);

        chk("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
